rtc_bus_sequencer: RTL and testbench

- Bus-cycle engine between the RTC control FSM and the RTC chip's multiplexed 8-bit address/data bus.
- Turns level requests (win/rin plus address and data) into timed two-phase bus cycles: an address phase, then a data phase.
- Captures read data and returns one-cycle donew/doner pulses that advance the control FSM's sub-state machines.

---
 rtl/rtc_pkg.sv | 74 +++++++
 rtl/rtc_bus_sequencer_if.sv | 29 ++
 rtl/rtc_phase_timer.sv | 29 ++
 rtl/rtc_bus_sequencer.sv | 154 +++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus-cycle engine: state encoding, default
// timing, RTC register map and the bus-request / pin-set records.
package rtc_pkg;

  localparam int SETUP_CYC_DEF  = 2;
  localparam int STROBE_CYC_DEF = 4;
  localparam int HOLD_CYC_DEF   = 2;
  localparam int REC_CYC_DEF    = 3;
  localparam int CNT_W_DEF      = 4;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_A_SETUP  = 4'd1;
  localparam logic [3:0] ST_A_STROBE = 4'd2;
  localparam logic [3:0] ST_A_HOLD   = 4'd3;
  localparam logic [3:0] ST_D_SETUP  = 4'd4;
  localparam logic [3:0] ST_D_STROBE = 4'd5;
  localparam logic [3:0] ST_D_HOLD   = 4'd6;
  localparam logic [3:0] ST_DONE     = 4'd7;
  localparam logic [3:0] ST_RECOVER  = 4'd8;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    A_SETUP  = ST_A_SETUP,
    A_STROBE = ST_A_STROBE,
    A_HOLD   = ST_A_HOLD,
    D_SETUP  = ST_D_SETUP,
    D_STROBE = ST_D_STROBE,
    D_HOLD   = ST_D_HOLD,
    DONE     = ST_DONE,
    RECOVER  = ST_RECOVER
  } seq_state_t;

  // RTC register map
  localparam logic [7:0] RTC_REG_CTRL    = 8'h02;
  localparam logic [7:0] RTC_REG_TIME_0  = 8'h21;
  localparam logic [7:0] RTC_REG_TIME_1  = 8'h22;
  localparam logic [7:0] RTC_REG_TIME_2  = 8'h23;
  localparam logic [7:0] RTC_REG_TIME_3  = 8'h24;
  localparam logic [7:0] RTC_REG_TIME_4  = 8'h25;
  localparam logic [7:0] RTC_REG_TIME_5  = 8'h26;
  localparam logic [7:0] RTC_REG_TIMER_0 = 8'h41;
  localparam logic [7:0] RTC_REG_TIMER_1 = 8'h42;
  localparam logic [7:0] RTC_REG_TIMER_2 = 8'h43;
  localparam logic [7:0] RTC_CMD_XFER_1  = 8'hF1;
  localparam logic [7:0] RTC_CMD_XFER_2  = 8'hF2;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    dir_t       dir;
  } bus_req_t;

  typedef struct packed {
    logic       cs_n;
    logic       ad_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic       donew;
    logic       doner;
  } bus_pins_t;

  localparam bus_pins_t PINS_IDLE = '{
    cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1,
    ad_oe: 1'b0, ad_out: 8'h00, donew: 1'b0, doner: 1'b0
  };

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request and multiplexed-bus signals between the control FSM / pad ring
// (master) and the bus-cycle engine (slave).
interface rtc_bus_sequencer_if;
  logic       win;
  logic       rin;
  logic [7:0] address;
  logic [7:0] datai;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic       donew;
  logic       doner;
  logic [7:0] data_rd;
  logic       busy;

  modport master (
    output win, rin, address, datai, ad_in,
    input  ad_out, ad_oe, cs_n, ad_n, wr_n, rd_n, donew, doner, data_rd, busy
  );

  modport slave (
    input  win, rin, address, datai, ad_in,
    output ad_out, ad_oe, cs_n, ad_n, wr_n, rd_n, donew, doner, data_rd, busy
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable phase counter: clears on load, otherwise counts up; tc flags the
// last cycle of the current phase.
module rtc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] last,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle engine: turns win/rin level requests into timed address + data
// phases on the RTC's multiplexed bus and returns donew/doner pulses.
module rtc_bus_sequencer
  import rtc_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int REC_CYC    = REC_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  rtc_bus_sequencer_if.slave bus
);

  localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CD  = (HOLD_CYC > REC_CYC) ? HOLD_CYC : REC_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || REC_CYC < 2) begin : g_bad_timing
    $error("rtc_bus_sequencer: phase lengths must be >= 1 and REC_CYC >= 2");
  end
  if (CNT_W < 1 || MAX_CYC > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("rtc_bus_sequencer: CNT_W too narrow for the longest phase");
  end

  seq_state_t       state, state_next;
  bus_req_t         req_q, req_n;
  bus_pins_t        pins_q, pins_n;
  logic             accept;
  logic             load;
  logic             tc;
  logic [CNT_W-1:0] last;
  logic [7:0]       data_rd_q;
  logic             busy_q;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .last  (last),
    .tc    (tc)
  );

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.win || bus.rin) begin
          state_next = A_SETUP;
          accept     = 1'b1;
        end
      end
      A_SETUP:  if (tc) state_next = A_STROBE;
      A_STROBE: if (tc) state_next = A_HOLD;
      A_HOLD:   if (tc) state_next = D_SETUP;
      D_SETUP:  if (tc) state_next = D_STROBE;
      D_STROBE: if (tc) state_next = D_HOLD;
      D_HOLD:   if (tc) state_next = DONE;
      DONE:     state_next = RECOVER;
      RECOVER:  if (tc) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign load = (state_next != state) || (state == IDLE);

  always_comb begin
    last = '0;
    unique case (state)
      A_SETUP,  D_SETUP:  last = CNT_W'(SETUP_CYC - 1);
      A_STROBE, D_STROBE: last = CNT_W'(STROBE_CYC - 1);
      A_HOLD,   D_HOLD:   last = CNT_W'(HOLD_CYC - 1);
      RECOVER:            last = CNT_W'(REC_CYC - 1);
      default:            last = '0;
    endcase
  end

  // win wins a tie; once latched, the request is frozen for the whole cycle
  always_comb begin
    req_n = req_q;
    if (accept) begin
      req_n.addr = bus.address;
      req_n.data = bus.datai;
      req_n.dir  = bus.win ? DIR_WRITE : DIR_READ;
    end
  end

  // Pins are decoded from the next state and registered, so they change on
  // the same edge as the state and no input reaches an output combinationally.
  always_comb begin
    pins_n = PINS_IDLE;
    unique case (state_next)
      A_SETUP, A_STROBE, A_HOLD: begin
        pins_n.cs_n   = 1'b0;
        pins_n.ad_n   = 1'b0;
        pins_n.ad_oe  = 1'b1;
        pins_n.ad_out = req_n.addr;
        pins_n.wr_n   = (state_next != A_STROBE);
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        pins_n.cs_n = 1'b0;
        pins_n.ad_n = 1'b1;
        if (req_n.dir == DIR_WRITE) begin
          pins_n.ad_oe  = 1'b1;
          pins_n.ad_out = req_n.data;
          pins_n.wr_n   = (state_next != D_STROBE);
        end else begin
          pins_n.rd_n   = (state_next != D_STROBE);
        end
      end
      DONE: begin
        pins_n.donew = (req_n.dir == DIR_WRITE);
        pins_n.doner = (req_n.dir == DIR_READ);
      end
      default: pins_n = PINS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_q     <= '0;
      pins_q    <= PINS_IDLE;
      data_rd_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state  <= state_next;
      req_q  <= req_n;
      pins_q <= pins_n;
      busy_q <= (state_next != IDLE);
      // sample the pad on the final strobe cycle, while rd_n is still low
      if (state == D_STROBE && tc && req_q.dir == DIR_READ) begin
        data_rd_q <= bus.ad_in;
      end
    end
  end

  assign bus.cs_n    = pins_q.cs_n;
  assign bus.ad_n    = pins_q.ad_n;
  assign bus.wr_n    = pins_q.wr_n;
  assign bus.rd_n    = pins_q.rd_n;
  assign bus.ad_oe   = pins_q.ad_oe;
  assign bus.ad_out  = pins_q.ad_out;
  assign bus.donew   = pins_q.donew;
  assign bus.doner   = pins_q.doner;
  assign bus.data_rd = data_rd_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: single write/read cycles, priority,
// input latching, asynchronous reset and a 13-write init replay.
module tb_rtc_bus_sequencer;
  import rtc_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rd_val = 8'h37;
  int         total = 0;
  int         bad   = 0;

  always #5 clock = ~clock;

  rtc_bus_sequencer_if bus ();

  // chip model: drives the read byte only while rd_n is low
  assign bus.ad_in = bus.rd_n ? 8'hFF : rd_val;

  rtc_bus_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic       r_cs   [64];
  logic       r_adn  [64];
  logic       r_wr   [64];
  logic       r_rd   [64];
  logic       r_oe   [64];
  logic       r_dw   [64];
  logic       r_dr   [64];
  logic       r_busy [64];
  logic [7:0] r_out  [64];
  logic [7:0] r_drd  [64];

  logic [7:0] tbl_a [13];
  logic [7:0] tbl_d [13];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle c is sampled on the falling edge after the c-th rising edge that
  // follows the request being applied; c=1 is the first cycle after acceptance.
  task automatic rec(input int first, input int last);
    for (int c = first; c <= last; c++) begin
      @(negedge clock);
      r_cs[c]   = bus.cs_n;
      r_adn[c]  = bus.ad_n;
      r_wr[c]   = bus.wr_n;
      r_rd[c]   = bus.rd_n;
      r_oe[c]   = bus.ad_oe;
      r_dw[c]   = bus.donew;
      r_dr[c]   = bus.doner;
      r_busy[c] = bus.busy;
      r_out[c]  = bus.ad_out;
      r_drd[c]  = bus.data_rd;
    end
  endtask

  function automatic logic [15:0] low_mask(input logic a[64]);
    logic [15:0] m;
    m = '0;
    for (int c = 1; c <= 16; c++) m[c-1] = ~a[c];
    return m;
  endfunction

  function automatic int count_hi(input logic a[64], input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) if (a[c] === 1'b1) n++;
    return n;
  endfunction

  function automatic logic phase_ok(input int lo, input int hi, input logic adn,
                                    input logic oe, input logic [7:0] v);
    logic ok;
    ok = 1'b1;
    for (int c = lo; c <= hi; c++) begin
      if (r_cs[c] !== 1'b0 || r_adn[c] !== adn || r_oe[c] !== oe) ok = 1'b0;
      if (oe && r_out[c] !== v) ok = 1'b0;
    end
    return ok;
  endfunction

  initial begin
    int idx, run, bad_runs, falls;
    logic prev_cs;
    logic [7:0] seen_a, seen_d;

    tbl_a = '{RTC_REG_CTRL, RTC_REG_TIME_0, RTC_REG_TIME_1, RTC_REG_TIME_2,
              RTC_REG_TIME_3, RTC_REG_TIME_4, RTC_REG_TIME_5, RTC_REG_TIMER_0,
              RTC_REG_TIMER_1, RTC_REG_TIMER_2, RTC_REG_CTRL, RTC_CMD_XFER_1,
              RTC_CMD_XFER_2};
    tbl_d = '{8'h00, 8'h00, 8'h30, 8'h12, 8'h15, 8'h06, 8'h24,
              8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00};

    bus.win = 1'b0;
    bus.rin = 1'b0;
    bus.address = 8'h00;
    bus.datai = 8'h00;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_ctrl", {bus.cs_n, bus.wr_n, bus.rd_n, bus.ad_n, bus.ad_oe,
                       bus.donew, bus.doner, bus.busy}, 8'b1111_0000);
    check("rst_ad_out", bus.ad_out, 8'h00);
    check("rst_data_rd", bus.data_rd, 8'h00);
    reset = 1'b1;
    @(negedge clock);

    // single write 0x45 -> 0x21
    bus.address = 8'h21; bus.datai = 8'h45; bus.win = 1'b1;
    rec(1, 1);
    bus.win = 1'b0;
    rec(2, 25);
    check("w_addr_phase", phase_ok(1, 8, 1'b0, 1'b1, 8'h21), 1);
    check("w_data_phase", phase_ok(9, 16, 1'b1, 1'b1, 8'h45), 1);
    check("w_wr_mask", low_mask(r_wr), 16'h3C3C);
    check("w_rd_mask", low_mask(r_rd), 16'h0000);
    check("w_donew_cnt", count_hi(r_dw, 1, 25), 1);
    check("w_donew_c17", r_dw[17], 1'b1);
    check("w_doner_cnt", count_hi(r_dr, 1, 25), 0);
    check("w_done_cs_oe", {r_cs[17], r_oe[17]}, 2'b10);
    check("w_busy_tail", count_hi(r_busy, 17, 25), 4);
    check("w_idle_c21", r_busy[21], 1'b0);

    // single read of 0x43, chip returns 0x37
    bus.address = 8'h43; bus.rin = 1'b1;
    rec(1, 1);
    bus.rin = 1'b0;
    rec(2, 25);
    check("r_addr_phase", phase_ok(1, 8, 1'b0, 1'b1, 8'h43), 1);
    check("r_data_phase_oe0", phase_ok(9, 16, 1'b1, 1'b0, 8'h00), 1);
    check("r_rd_mask", low_mask(r_rd), 16'h3C00);
    check("r_wr_mask", low_mask(r_wr), 16'h003C);
    check("r_doner_cnt", count_hi(r_dr, 1, 25), 1);
    check("r_doner_c17", r_dr[17], 1'b1);
    check("r_donew_cnt", count_hi(r_dw, 1, 25), 0);
    check("r_data_rd_before", r_drd[14], 8'h00);
    check("r_data_rd_done", r_drd[17], 8'h37);

    // win and rin together: write first, read back-to-back after recovery
    bus.address = RTC_REG_CTRL; bus.datai = 8'h5A; bus.win = 1'b1; bus.rin = 1'b1;
    rec(1, 17);
    bus.win = 1'b0;
    rec(18, 38);
    bus.rin = 1'b0;
    rec(39, 45);
    check("s_write_data", phase_ok(9, 16, 1'b1, 1'b1, 8'h5A), 1);
    check("s_donew_c17", r_dw[17], 1'b1);
    check("s_doner_early", count_hi(r_dr, 1, 37), 0);
    check("s_gap_idle", {r_busy[20], r_busy[21], r_busy[22]}, 3'b101);
    check("s_restart_c22", {r_cs[22], r_adn[22], r_out[22]}, {2'b00, RTC_REG_CTRL});
    check("s_doner_c38", r_dr[38], 1'b1);
    check("s_donew_late", count_hi(r_dw, 18, 45), 0);
    check("s_no_extra", count_hi(r_busy, 42, 45), 0);

    // inputs change during A_STROBE: bus keeps the latched values
    bus.address = 8'h21; bus.datai = 8'h45; bus.win = 1'b1;
    rec(1, 1);
    bus.win = 1'b0;
    rec(2, 3);
    bus.address = 8'h99; bus.datai = 8'h00;
    rec(4, 25);
    check("l_addr_latched", phase_ok(1, 8, 1'b0, 1'b1, 8'h21), 1);
    check("l_data_latched", phase_ok(9, 16, 1'b1, 1'b1, 8'h45), 1);
    check("l_donew_c17", r_dw[17], 1'b1);

    // asynchronous reset in the middle of D_STROBE
    bus.address = 8'h24; bus.datai = 8'h15; bus.win = 1'b1;
    rec(1, 12);
    check("a_in_strobe", {r_cs[12], r_wr[12]}, 2'b00);
    #2 reset = 1'b0;
    #1;
    check("a_release", {bus.cs_n, bus.wr_n, bus.ad_oe, bus.busy, bus.donew}, 5'b11000);
    check("a_data_rd_clr", bus.data_rd, 8'h00);
    rec(1, 3);
    check("a_no_done", count_hi(r_dw, 1, 3) + count_hi(r_dr, 1, 3), 0);
    reset = 1'b1;
    rec(1, 1);
    bus.win = 1'b0;
    rec(2, 25);
    check("a_fresh_addr", phase_ok(1, 8, 1'b0, 1'b1, 8'h24), 1);
    check("a_fresh_early", count_hi(r_dw, 1, 16), 0);
    check("a_fresh_done", r_dw[17], 1'b1);

    // 13-write init replay, the request advancing on each donew
    idx = 0; run = 0; bad_runs = 0; falls = 0; prev_cs = 1'b1;
    seen_a = 8'h00; seen_d = 8'h00;
    bus.address = tbl_a[0]; bus.datai = tbl_d[0]; bus.win = 1'b1;
    for (int cyc = 0; cyc < 400 && idx < 13; cyc++) begin
      @(negedge clock);
      if (!bus.cs_n) run++;
      else if (run != 0) begin
        if (run != 16) bad_runs++;
        run = 0;
      end
      if (prev_cs && !bus.cs_n) falls++;
      prev_cs = bus.cs_n;
      if (!bus.cs_n && !bus.ad_n) seen_a = bus.ad_out;
      if (!bus.cs_n && bus.ad_n && !bus.wr_n) seen_d = bus.ad_out;
      if (bus.donew) begin
        check($sformatf("init%0d_addr", idx), seen_a, tbl_a[idx]);
        check($sformatf("init%0d_data", idx), seen_d, tbl_d[idx]);
        idx++;
        if (idx < 13) begin
          bus.address = tbl_a[idx];
          bus.datai   = tbl_d[idx];
        end else begin
          bus.win = 1'b0;
        end
      end
    end
    check("init_pulses", idx, 13);
    check("init_cs_falls", falls, 13);
    check("init_cs_runs", bad_runs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
